// File: rtl/conv_frame_sched.sv
// rtl/conv_frame_sched.sv - frame-level scheduler for the 3x3 convolution accelerator
// Programs the kernel once, then per output fetches 9 pixels, kicks and polls the accelerator, and stores the result.
module conv_frame_sched #(
  parameter int AW   = 16,
  parameter int DIMW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    addr,
  input  logic          en,
  input  logic          we,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic [5:0]    acc_addr,
  output logic          acc_en,
  output logic          acc_we,
  output logic [31:0]   acc_din,
  input  logic [31:0]   acc_dout,
  output logic [AW-1:0] img_addr,
  input  logic [31:0]   img_rdata,
  output logic [AW-1:0] out_addr,
  output logic          out_we,
  output logic [31:0]   out_wdata,
  output logic          done_pulse
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_FETCH, S_START, S_GAP, S_POLL, S_READ
  } state_t;

  state_t state, state_nx;

  logic [DIMW-1:0] img_w, img_h, r, c;
  logic [AW-1:0]   img_base, out_base;
  logic [31:0]     kern [0:8];
  logic [31:0]     count;
  logic [3:0]      cnt;
  logic            done, err, wr_q;

  logic            busy, start_req, abort_now, geom_ok, last_pos;
  logic [3:0]      cpu_kidx, kc4;
  logic [1:0]      kr;
  logic [AW-1:0]   row;

  assign start_req = en && we && (addr == 6'h00) && din[0];
  assign busy      = (state != S_IDLE) || wr_q;
  assign abort_now = en && we && (addr == 6'h00) && din[1] && (state != S_IDLE);
  assign geom_ok   = (img_w >= DIMW'(3)) && (img_h >= DIMW'(3));
  assign last_pos  = (r == img_h - DIMW'(3)) && (c == img_w - DIMW'(3));
  assign cpu_kidx  = 4'(addr - 6'h10);
  // An aborted cycle must not commit the result that was scheduled for it
  assign out_we    = wr_q && !abort_now;

  // Window tap k maps to row offset k/3 and column offset k%3
  assign kr  = (cnt >= 4'd6) ? 2'd2 : (cnt >= 4'd3) ? 2'd1 : 2'd0;
  assign kc4 = cnt - 4'(kr) * 4'd3;
  assign row = AW'(r) + AW'(kr);

  always_comb begin
    state_nx = state;
    acc_en   = 1'b0;
    acc_we   = 1'b0;
    acc_addr = 6'h00;
    acc_din  = 32'd0;
    img_addr = '0;
    case (state)
      S_IDLE: if (start_req && !busy && geom_ok) state_nx = S_LOAD_K;
      S_LOAD_K: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = 6'h10 + 6'(cnt);
        acc_din  = kern[cnt];
        if (cnt == 4'd8) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (cnt < 4'd9)
          img_addr = img_base + row * AW'(img_w) + AW'(c) + AW'(kc4[1:0]);
        // Memory data arrives one cycle after its address, so the write trails by one
        if (cnt != 4'd0) begin
          acc_en   = 1'b1;
          acc_we   = 1'b1;
          acc_addr = 6'h20 + 6'(cnt - 4'd1);
          acc_din  = img_rdata;
        end
        if (cnt == 4'd9) state_nx = S_START;
      end
      S_START: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = 6'h00;
        acc_din  = 32'd1;
        state_nx = S_GAP;
      end
      S_GAP: if (cnt == 4'd1) state_nx = S_POLL;
      S_POLL: begin
        acc_en   = 1'b1;
        acc_addr = 6'h01;
        if (acc_dout[1] && !acc_dout[0]) state_nx = S_READ;
      end
      S_READ: begin
        acc_en   = 1'b1;
        acc_addr = 6'h02;
        state_nx = last_pos ? S_IDLE : S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort_now) begin
      state_nx = S_IDLE;
      acc_en   = 1'b0;
      acc_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      img_w      <= '0;
      img_h      <= '0;
      img_base   <= '0;
      out_base   <= '0;
      for (int i = 0; i < 9; i++) kern[i] <= 32'd0;
      count      <= 32'd0;
      cnt        <= 4'd0;
      r          <= '0;
      c          <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      wr_q       <= 1'b0;
      out_addr   <= '0;
      out_wdata  <= 32'd0;
      done_pulse <= 1'b0;
    end else begin
      cnt        <= (state == S_IDLE || state_nx != state) ? 4'd0 : cnt + 4'd1;
      wr_q       <= 1'b0;
      done_pulse <= 1'b0;
      if (en && we && !busy) begin
        case (addr)
          6'h02: img_w    <= din[DIMW-1:0];
          6'h03: img_h    <= din[DIMW-1:0];
          6'h04: img_base <= din[AW-1:0];
          6'h05: out_base <= din[AW-1:0];
          default: if (addr >= 6'h10 && addr <= 6'h18) kern[cpu_kidx] <= din;
        endcase
      end
      if (state == S_IDLE && start_req && !busy) begin
        done <= 1'b0;
        if (geom_ok) begin
          err   <= 1'b0;
          count <= 32'd0;
          r     <= '0;
          c     <= '0;
        end else begin
          err <= 1'b1;
        end
      end
      if (out_we) count <= count + 32'd1;
      if (state == S_READ && !abort_now) begin
        out_wdata <= acc_dout;
        out_addr  <= out_base + AW'(count);
        wr_q      <= 1'b1;
        if (c == img_w - DIMW'(3)) begin
          c <= '0;
          r <= r + DIMW'(1);
        end else begin
          c <= c + DIMW'(1);
        end
        if (last_pos) begin
          done       <= 1'b1;
          done_pulse <= 1'b1;
        end
      end
      if (abort_now) done <= 1'b0;
    end
  end

  always_comb begin
    dout = 32'd0;
    if (en && !we) begin
      case (addr)
        6'h01: dout = {29'd0, err, done, busy};
        6'h02: dout = 32'(img_w);
        6'h03: dout = 32'(img_h);
        6'h04: dout = 32'(img_base);
        6'h05: dout = 32'(out_base);
        6'h06: dout = count;
        default: if (addr >= 6'h10 && addr <= 6'h18) dout = kern[cpu_kidx];
      endcase
    end
  end
endmodule

// File: tb/tb_conv_frame_sched.sv
// tb/tb_conv_frame_sched.sv - scoreboard bench for conv_frame_sched with accelerator and memory models
module tb_conv_frame_sched;
  localparam int AW = 16, DIMW = 12;

  logic          clk = 1'b0, rst = 1'b1;
  logic [5:0]    addr = 6'd0;
  logic          en = 1'b0, we = 1'b0;
  logic [31:0]   din = 32'd0;
  logic [31:0]   dout, acc_din, acc_dout, img_rdata, out_wdata;
  logic [5:0]    acc_addr;
  logic          acc_en, acc_we, out_we, done_pulse;
  logic [AW-1:0] img_addr, out_addr;

  always #5 clk = ~clk;

  conv_frame_sched #(.AW(AW), .DIMW(DIMW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .en(en), .we(we), .din(din), .dout(dout),
    .acc_addr(acc_addr), .acc_en(acc_en), .acc_we(acc_we), .acc_din(acc_din),
    .acc_dout(acc_dout), .img_addr(img_addr), .img_rdata(img_rdata),
    .out_addr(out_addr), .out_we(out_we), .out_wdata(out_wdata), .done_pulse(done_pulse)
  );

  int n_tests = 0, n_fail = 0;
  int polls = 0, act = 0, nwr = 0, dp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Accelerator: register file, MAC result, done after acc_lat edges
  logic [31:0] acc_regs [0:63];
  logic signed [31:0] acc_res;
  int  acc_lat = 1, acc_cd = 0;
  logic acc_started = 1'b0;
  initial for (int i = 0; i < 64; i++) acc_regs[i] = 32'd0;

  always @(posedge clk) begin
    if (acc_en && acc_we) begin
      acc_regs[acc_addr] <= acc_din;
      if (acc_addr == 6'd0 && acc_din[0]) begin
        acc_started <= 1'b1;
        acc_cd      <= acc_lat;
      end
    end else if (acc_cd > 0) begin
      acc_cd <= acc_cd - 1;
    end
  end

  always_comb begin
    acc_res = 32'sd0;
    for (int i = 0; i < 9; i++)
      acc_res = acc_res + $signed(acc_regs[16+i]) * $signed(acc_regs[32+i]);
  end

  always_comb begin
    acc_dout = 32'd0;
    case (acc_addr)
      6'd1: acc_dout = {30'd0, acc_started && acc_cd == 0, acc_started && acc_cd != 0};
      6'd2: acc_dout = acc_res;
      default: acc_dout = 32'd0;
    endcase
  end

  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  always @(posedge clk) img_rdata <= mem[img_addr[7:0]];

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];
  int  kk [0:8];

  always @(negedge clk) begin
    wr_t e;
    if (acc_en && !acc_we && acc_addr == 6'd1) polls++;
    if (acc_en || img_addr != '0 || out_we) act++;
    if (done_pulse) dp_cnt++;
    if (out_we) begin
      nwr++;
      if (sb.size() == 0) check("unexpected_out_we", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("out_addr", 32'(out_addr), e.a);
        check("out_wdata", out_wdata, e.d);
      end
    end
  end

  task automatic push_job(input int w, input int h, input int ib, input int ob);
    logic signed [31:0] s;
    wr_t e;
    for (int r = 0; r < h - 2; r++)
      for (int c = 0; c < w - 2; c++) begin
        s = 0;
        for (int k = 0; k < 9; k++)
          s = s + kk[k] * $signed(mem[(ib + (r + k / 3) * w + c + k % 3) & 255]);
        e.a = 32'((ob + r * (w - 2) + c) & 16'hFFFF);
        e.d = s;
        sb.push_back(e);
      end
  endtask

  task automatic cpu_wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = a;
    #1 d = dout;
    en = 1'b0;
  endtask

  task automatic setup(input int w, input int h, input int ib, input int ob);
    cpu_wr(6'h02, 32'(w));
    cpu_wr(6'h03, 32'(h));
    cpu_wr(6'h04, 32'(ib));
    cpu_wr(6'h05, 32'(ob));
    for (int k = 0; k < 9; k++) cpu_wr(6'h10 + 6'(k), 32'(kk[k]));
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] s;
    int i;
    for (i = 0; i < budget; i++) begin
      cpu_rd(6'h01, s);
      if (!s[0]) break;
    end
    if (i >= budget) check("timeout_busy", 32'd1, 32'd0);
  endtask

  task automatic run_job(input string tag, input int w, input int h, input int ib, input int ob,
                         input int exp_polls);
    logic [31:0] v;
    setup(w, h, ib, ob);
    push_job(w, h, ib, ob);
    polls = 0; dp_cnt = 0;
    cpu_wr(6'h00, 32'd1);
    wait_idle(2000);
    cpu_rd(6'h06, v);
    check({tag, "_count"}, v, 32'((w - 2) * (h - 2)));
    cpu_rd(6'h01, v);
    check({tag, "_status"}, v, 32'b010);
    check({tag, "_done_pulses"}, 32'(dp_cnt), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    if (exp_polls >= 0) check({tag, "_polls"}, 32'(polls), 32'(exp_polls));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int i;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", 32'(|{acc_en, acc_we, acc_addr, acc_din, img_addr, out_we,
                               out_addr, out_wdata, done_pulse, dout}), 32'd0);
    cpu_rd(6'h01, v); check("rst_status", v, 32'd0);
    cpu_rd(6'h02, v); check("rst_img_w", v, 32'd0);

    // Counting frame
    for (int k = 0; k < 16; k++) mem[8'h40 + k] = 32'(k + 1);
    for (int k = 0; k < 9; k++) kk[k] = 1;
    run_job("count", 4, 4, 16'h40, 16'h100, 4);
    cpu_rd(6'h12, v); check("rd_k2", v, 32'd1);
    cpu_rd(6'h04, v); check("rd_img_base", v, 32'h40);

    // Signed arithmetic
    for (int k = 0; k < 9; k++) begin kk[k] = 0; mem[8'h80 + k] = 32'd5; end
    kk[4] = -1;
    run_job("signed3x3", 3, 3, 16'h80, 16'h200, -1);
    for (int k = 0; k < 15; k++) mem[8'h90 + k] = 32'(k * 3 + 1);
    run_job("signed5x3", 5, 3, 16'h90, 16'h210, -1);

    // Geometry error
    cpu_wr(6'h02, 32'd2);
    act = 0;
    cpu_wr(6'h00, 32'd1);
    repeat (20) @(negedge clk);
    check("geom_activity", 32'(act), 32'd0);
    cpu_rd(6'h01, v); check("geom_status", v, 32'b100);

    // Slow accelerator: six extra POLL cycles per output
    for (int k = 0; k < 9; k++) kk[k] = 1;
    acc_lat = 8;
    run_job("slow", 4, 4, 16'h40, 16'h100, 28);
    acc_lat = 1;

    // Abort during second FETCH, then restart
    push_job(4, 4, 16'h40, 16'h100);
    nwr = 0;
    cpu_wr(6'h00, 32'd1);
    for (i = 0; i < 200; i++) begin
      @(posedge clk);
      if (nwr >= 1) break;
    end
    if (i >= 200) check("abort_first_wr_timeout", 32'd1, 32'd0);
    cpu_wr(6'h00, 32'd2);
    cpu_rd(6'h01, v); check("abort_status", v, 32'd0);
    cpu_rd(6'h06, v); check("abort_count", v, 32'd1);
    check("abort_pending", 32'(sb.size()), 32'd3);
    sb.delete();
    repeat (40) @(negedge clk);
    run_job("restart", 4, 4, 16'h40, 16'h100, 4);

    // Reset while polling a stalled accelerator
    acc_lat = 200;
    cpu_wr(6'h00, 32'd1);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_en && !acc_we && acc_addr == 6'd1) break;
    end
    if (i >= 100) check("poll_reach_timeout", 32'd1, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outputs", 32'(|{acc_en, acc_we, acc_addr, acc_din, img_addr, out_we,
                                  out_addr, out_wdata, done_pulse, dout}), 32'd0);
    cpu_rd(6'h01, v); check("midrst_status", v, 32'd0);
    cpu_rd(6'h02, v); check("midrst_img_w", v, 32'd0);
    cpu_rd(6'h14, v); check("midrst_k4", v, 32'd0);
    cpu_rd(6'h06, v); check("midrst_count", v, 32'd0);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
